// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with configurable data width,
// parity and stop bits. Delivers each frame through a valid/ready handshake
// together with parity, framing, overrun and break flags.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic [3:0]           error,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_badParams
      $error("uart_rx_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic                   r_rxMeta;
  logic                   r_rxSync;
  logic                   w_rxs;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bitCnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parErr;
  logic                   r_parZero;
  logic                   r_frmErr;
  logic                   r_stop1Low;
  logic                   r_complete;
  logic                   w_tick;
  logic                   w_lastData;
  logic                   w_lastStop;
  logic                   w_frmNow;
  logic                   w_parErrNow;
  logic                   w_break;

  assign w_rxs       = r_rxSync;
  assign w_lastData  = (r_bitCnt == LAST_DATA);
  assign w_lastStop  = (r_bitCnt == LAST_STOP);
  assign w_frmNow    = r_frmErr | ~w_rxs;
  assign w_parErrNow = ((^r_shift) ^ w_rxs) != (PARITY_MODE == 2);
  assign w_break     = (r_shift == '0) && ((PARITY_MODE == 0) || r_parZero) && r_stop1Low;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= rx;
      r_rxSync <= r_rxMeta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a framing failure parks in WAIT_HIGH until the line idles.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (!w_rxs) w_nextState = START;
      end
      START: begin
        if (w_tick) w_nextState = w_rxs ? IDLE : DATA;
      end
      DATA: begin
        if (w_tick && w_lastData) w_nextState = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (w_tick) w_nextState = STOP;
      end
      STOP: begin
        if (w_tick && w_lastStop) w_nextState = w_frmNow ? WAIT_HIGH : IDLE;
      end
      WAIT_HIGH: begin
        if (w_rxs) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State-decoded outputs: busy outside IDLE, sample tick when the bit counter expires.
  always_comb begin
    busy   = 1'b1;
    w_tick = 1'b0;
    case (r_state)
      IDLE:                      busy   = 1'b0;
      START, DATA, PARITY, STOP: w_tick = (r_cnt == '0);
      default:                   w_tick = 1'b0;
    endcase
  end

  // Bit timing, data shift and per-frame flag collection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_parErr   <= 1'b0;
      r_parZero  <= 1'b0;
      r_frmErr   <= 1'b0;
      r_stop1Low <= 1'b0;
      r_complete <= 1'b0;
    end else begin
      r_complete <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            r_cnt      <= HALF_LOAD;
            r_bitCnt   <= '0;
            r_parErr   <= 1'b0;
            r_parZero  <= 1'b0;
            r_frmErr   <= 1'b0;
            r_stop1Low <= 1'b0;
          end
        end
        START, DATA, PARITY, STOP: begin
          r_cnt <= w_tick ? FULL_LOAD : r_cnt - 1'b1;
          if (w_tick) begin
            if (r_state == DATA) begin
              r_shift  <= {w_rxs, r_shift[DATA_BITS-1:1]};
              r_bitCnt <= w_lastData ? '0 : r_bitCnt + 1'b1;
            end
            if (r_state == PARITY) begin
              r_parErr  <= w_parErrNow;
              r_parZero <= ~w_rxs;
            end
            if (r_state == STOP) begin
              if (!w_rxs) r_frmErr <= 1'b1;
              if (!w_rxs && r_bitCnt == '0) r_stop1Low <= 1'b1;
              r_bitCnt <= r_bitCnt + 1'b1;
              if (w_lastStop) r_complete <= 1'b1;
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Output holding register and valid/ready handshake with overrun detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      error    <= '0;
      valid    <= 1'b0;
    end else if (r_complete) begin
      data_out <= r_shift;
      error    <= {w_break, r_frmErr, valid && !ready, r_parErr};
      valid    <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule
